dram_rmw_bridge: RTL and testbench
==================================

Name: dram_rmw_bridge

Overview:
Sits directly downstream of the bus arbiter and consumes its muxed DRAM request (address, wdata, we/le strobes, ctrl) and returns odata and busy. It converts byte/half/word core accesses into full-word transactions on a native 32-bit DRAM controller port. Sub-word stores use read-modify-write. Sub-word loads are extracted and sign- or zero-extended.

Parameters:
MEM_AW, 27, byte-address width of the DRAM window; mem_addr carries word address bits [MEM_AW-1:2]
CMD_TIMEOUT, 255, cycles to wait for mem_ready/mem_rvalid before aborting with error; 0 disables the timeout

Ports:
CLK  in  1  system clock
RST_X  in  1  synchronous active-low reset
w_dram_addr  in  32  byte address from arbiter
w_dram_wdata  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0])
w_dram_we_t  in  1  one-cycle write request strobe
w_dram_le  in  1  one-cycle load request strobe
w_dram_ctrl  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
w_dram_odata  out  32  load result, registered
w_dram_busy  out  1  bridge busy to arbiter
mem_addr  out  MEM_AW-2  word address to DRAM controller
mem_wdata  out  32  full-word write data
mem_we  out  1  write command, held until mem_ready
mem_re  out  1  read command, held until mem_ready
mem_ready  in  1  controller accepts the command this cycle
mem_rdata  in  32  read word
mem_rvalid  in  1  one-cycle read-data-valid pulse
r_err  out  1  sticky: misaligned access or timeout; cleared only by reset

Behaviour:
- Reset (RST_X=0 at a CLK edge): state=IDLE; all outputs 0; the latched request is cleared. Reset mid-transaction aborts it. A late mem_rvalid after reset is ignored.
- Busy: w_dram_busy = (state != IDLE) | w_dram_le | w_dram_we_t. This is combinational so the core sees busy in the strobe cycle.
- Request capture in IDLE: on a strobe, latch addr, wdata and ctrl. If we_t and le arrive together, the write wins and the load is dropped. Strobes outside IDLE are ignored.
- Misalignment: h/hu with addr[0]=1, or w with addr[1:0]!=0, sets r_err. The access proceeds with the offending low bits forced to 0.
- States: IDLE, RD_CMD, RD_WAIT, WR_CMD.
  - Load: IDLE->RD_CMD.
  - Word store (ctrl=010): IDLE->WR_CMD with mem_wdata=wdata.
  - Sub-word store: IDLE->RD_CMD (RMW flag set).
- RD_CMD: mem_re=1 until mem_ready, then go to RD_WAIT.
- RD_WAIT on mem_rvalid:
  - Load: register the extracted result into w_dram_odata and go to IDLE.
  - RMW: merge the store lane(s) into mem_rdata, load mem_wdata, go to WR_CMD.
- WR_CMD: mem_we=1 until mem_ready, then go to IDLE. w_dram_odata is unchanged by stores.
- mem_we and mem_re are never asserted together. mem_addr/mem_wdata stay stable while a command is held.
- Lane rules:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - b sign-extends the selected byte; bu zero-extends it. h/hu do the same for the half. w passes through.
  - Merge replaces only the addressed byte or half.
- Latency with mem_ready=1 and rvalid one cycle after acceptance (strobe at T):
  - Load: mem_re at T+1, rvalid at T+2, odata valid and busy low at T+3.
  - Word store: mem_we at T+1, busy low at T+2.
  - Sub-word store: busy low at T+4.
- Timeout: a per-state counter resets on each state entry. If it reaches CMD_TIMEOUT in RD_CMD, RD_WAIT or WR_CMD, set r_err, drop the command and return to IDLE. On a load timeout, odata=32'hFFFFFFFF.
- w_dram_odata holds its value until the next completed load.

Decomposition:
- Add the ctrl encodings (LS_B=3'b000, LS_H=3'b001, LS_W=3'b010, LS_BU=3'b100, LS_HU=3'b101) and the state encodings to define.vh.
- One combinational sub-module, dram_lane_align, provides extract(word, addr[1:0], ctrl) and merge(word, wdata, addr[1:0], ctrl). The FSM, latches and timeout counter live in dram_rmw_bridge.

Test Plan:
- Word load at 0x100 with mem_rdata=0xDEADBEEF, mem_ready=1, rvalid at T+2 -> mem_addr=0x40, odata=0xDEADBEEF at T+3, busy high T..T+2.
- lb at 0x103, lbu at 0x103, lh at 0x102, lhu at 0x102 on word 0x80FF7F01 -> odata 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF.
- sb 0xAA at 0x201 over existing 0x11223344 -> one mem_re, then mem_we with mem_wdata=0x1122AA44; sh 0xBEEF at 0x202 -> 0xBEEF3344.
- mem_ready low for 5 cycles during a word store -> mem_we and mem_addr held stable 6 cycles, exactly one accepted write, busy low the cycle after acceptance.
- we_t and le asserted together -> only the write occurs; a strobe while busy -> ignored; lh at 0x101 -> r_err=1, access performed at 0x100.
- RST_X low during RD_WAIT, then rvalid -> state IDLE, busy 0, odata 0, rvalid ignored. mem_ready stuck low with CMD_TIMEOUT=8 -> r_err=1 and IDLE after 8 cycles.

Source files
------------

// File: rtl/dram_rmw_bridge_pkg.sv
// Shared encodings for the DRAM read-modify-write bridge: access size/sign codes,
// FSM states and the low-address alignment helpers.
package dram_rmw_bridge_pkg;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_CMD  = 2'd1,
      RD_WAIT = 2'd2,
      WR_CMD  = 2'd3
   } state_t;

   // Clears the low address bits a half or word access cannot legally use.
   function automatic logic [1:0] align_off(input logic [1:0] off, input logic [2:0] ctrl);
      case (ctrl)
         LS_H, LS_HU: return {off[1], 1'b0};
         LS_W:        return 2'b00;
         default:     return off;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] off, input logic [2:0] ctrl);
      return align_off(off, ctrl) != off;
   endfunction

endpackage

// File: rtl/dram_lane_align.sv
// Combinational lane logic: extracts a sign/zero-extended byte or half from a word,
// and merges right-aligned store data into the addressed lane of a word.
module dram_lane_align
   import dram_rmw_bridge_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  off,
   input  logic [2:0]  ctrl,
   output logic [31:0] extract,
   output logic [31:0] merge
);

   logic [7:0]  bsel;
   logic [15:0] hsel;

   always_comb begin
      bsel    = word[{off, 3'b000} +: 8];
      hsel    = word[{off[1], 4'b0000} +: 16];
      extract = word;
      merge   = wdata;
      case (ctrl)
         LS_B: begin
            extract = {{24{bsel[7]}}, bsel};
            merge   = word;
            merge[{off, 3'b000} +: 8] = wdata[7:0];
         end
         LS_BU: begin
            extract = {24'h000000, bsel};
            merge   = word;
            merge[{off, 3'b000} +: 8] = wdata[7:0];
         end
         LS_H: begin
            extract = {{16{hsel[15]}}, hsel};
            merge   = word;
            merge[{off[1], 4'b0000} +: 16] = wdata[15:0];
         end
         LS_HU: begin
            extract = {16'h0000, hsel};
            merge   = word;
            merge[{off[1], 4'b0000} +: 16] = wdata[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dram_rmw_bridge.sv
// Converts byte/half/word core accesses into full-word DRAM controller commands,
// using read-modify-write for sub-word stores and a per-state command timeout.
module dram_rmw_bridge
   import dram_rmw_bridge_pkg::*;
#(
   parameter int MEM_AW      = 27,
   parameter int CMD_TIMEOUT = 255
) (
   input  logic              CLK,
   input  logic              RST_X,
   input  logic [31:0]       w_dram_addr,
   input  logic [31:0]       w_dram_wdata,
   input  logic              w_dram_we_t,
   input  logic              w_dram_le,
   input  logic [2:0]        w_dram_ctrl,
   output logic [31:0]       w_dram_odata,
   output logic              w_dram_busy,
   output logic [MEM_AW-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic              mem_ready,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_rvalid,
   output logic              r_err
);

   localparam int CW = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT + 1) : 1;

   state_t            state, state_nx;
   logic [MEM_AW-1:0] addr_q;
   logic [31:0]       wdata_q, mem_wdata_q, odata_q;
   logic [2:0]        ctrl_q;
   logic              rmw_q, err_q;
   logic [CW-1:0]     cnt_q;
   logic [31:0]       ext_w, merge_w;
   logic              strobe, cmd_done, timeout;
   logic              unused_addr_hi;

   assign strobe         = w_dram_we_t | w_dram_le;
   assign unused_addr_hi = ^w_dram_addr[31:MEM_AW];

   dram_lane_align u_align (
      .word    (mem_rdata),
      .wdata   (wdata_q),
      .off     (addr_q[1:0]),
      .ctrl    (ctrl_q),
      .extract (ext_w),
      .merge   (merge_w)
   );

   always_comb begin
      state_nx = state;
      cmd_done = 1'b0;
      case (state)
         IDLE: begin
            // A simultaneous load strobe is dropped in favour of the write.
            if (w_dram_we_t)
               state_nx = (w_dram_ctrl == LS_W) ? WR_CMD : RD_CMD;
            else if (w_dram_le)
               state_nx = RD_CMD;
         end
         RD_CMD: if (mem_ready) begin
            cmd_done = 1'b1;
            state_nx = RD_WAIT;
         end
         RD_WAIT: if (mem_rvalid) begin
            cmd_done = 1'b1;
            state_nx = rmw_q ? WR_CMD : IDLE;
         end
         WR_CMD: if (mem_ready) begin
            cmd_done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      timeout = (CMD_TIMEOUT != 0) && (state != IDLE) && !cmd_done &&
                (cnt_q == CW'(CMD_TIMEOUT - 1));
      if (timeout)
         state_nx = IDLE;
   end

   always_ff @(posedge CLK) begin
      if (!RST_X) begin
         state       <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ctrl_q      <= '0;
         rmw_q       <= 1'b0;
         mem_wdata_q <= '0;
         odata_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state <= state_nx;
         cnt_q <= (state == IDLE || state_nx != state) ? '0 : cnt_q + CW'(1);
         if (state == IDLE && strobe) begin
            addr_q  <= {w_dram_addr[MEM_AW-1:2], align_off(w_dram_addr[1:0], w_dram_ctrl)};
            wdata_q <= w_dram_wdata;
            ctrl_q  <= w_dram_ctrl;
            rmw_q   <= w_dram_we_t && (w_dram_ctrl != LS_W);
            if (w_dram_we_t)
               mem_wdata_q <= w_dram_wdata;
            if (misaligned(w_dram_addr[1:0], w_dram_ctrl))
               err_q <= 1'b1;
         end
         if (state == RD_WAIT && mem_rvalid) begin
            if (rmw_q)
               mem_wdata_q <= merge_w;
            else
               odata_q <= ext_w;
         end
         if (timeout) begin
            err_q <= 1'b1;
            if (!rmw_q && state != WR_CMD)
               odata_q <= '1;
         end
      end
   end

   assign w_dram_busy  = (state != IDLE) | strobe;
   assign w_dram_odata = odata_q;
   assign mem_addr     = addr_q[MEM_AW-1:2];
   assign mem_wdata    = mem_wdata_q;
   assign mem_re       = (state == RD_CMD);
   assign mem_we       = (state == WR_CMD);
   assign r_err        = err_q;

endmodule

// File: tb/tb_dram_rmw_bridge.sv
// Scoreboard bench: a DRAM responder model, a reference of the load/merge rules
// and a decoupled monitor that checks each request when the bridge drops busy.
module tb_dram_rmw_bridge;
   import dram_rmw_bridge_pkg::*;

   localparam int MEM_AW = 27;
   localparam int TMO    = 8;

   logic              CLK = 1'b0;
   logic              RST_X = 1'b0;
   logic [31:0]       w_dram_addr = '0;
   logic [31:0]       w_dram_wdata = '0;
   logic              w_dram_we_t = 1'b0;
   logic              w_dram_le = 1'b0;
   logic [2:0]        w_dram_ctrl = '0;
   logic [31:0]       w_dram_odata;
   logic              w_dram_busy;
   logic [MEM_AW-3:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_we, mem_re;
   logic              mem_ready = 1'b0;
   logic [31:0]       mem_rdata = '0;
   logic              mem_rvalid = 1'b0;
   logic              r_err;

   dram_rmw_bridge #(.MEM_AW(MEM_AW), .CMD_TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST_X(RST_X),
      .w_dram_addr(w_dram_addr), .w_dram_wdata(w_dram_wdata),
      .w_dram_we_t(w_dram_we_t), .w_dram_le(w_dram_le), .w_dram_ctrl(w_dram_ctrl),
      .w_dram_odata(w_dram_odata), .w_dram_busy(w_dram_busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
      .r_err(r_err)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got timeout expected completion", name);
   endtask

   // Backing store of the simulated DRAM, word indexed.
   logic [31:0] mem [int unsigned];

   function automatic logic [31:0] mem_rd(input int unsigned idx);
      if (mem.exists(idx)) return mem[idx];
      return (idx * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input int unsigned off,
                                            input logic [2:0] c);
      int unsigned v;
      case (c)
         LS_B, LS_BU: begin
            v = (w >> (8 * off)) % 256;
            if (c == LS_B && v >= 128) v = v + 32'hFFFFFF00;
         end
         LS_H, LS_HU: begin
            v = (w >> (8 * off)) % 65536;
            if (c == LS_H && v >= 32768) v = v + 32'hFFFF0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] wd,
                                             input int unsigned off, input logic [2:0] c);
      logic [31:0] mask;
      mask = ((c == LS_B || c == LS_BU) ? 32'hFF : 32'hFFFF) << (8 * off);
      return (w & ~mask) | ((wd << (8 * off)) & mask);
   endfunction

   typedef struct { int unsigned idx; logic [31:0] data; } wr_t;
   typedef struct {
      bit is_load; bit rd; bit wr; int unsigned idx; logic [31:0] val; bit err; int lat;
   } exp_t;

   int unsigned rdq[$];
   wr_t         wrq[$];
   exp_t        sbq[$];

   int ready_mode = 0;  // 0 ready, 1 random stalls, 2 stuck low, 3 five-cycle stall
   int rv_mode    = 0;  // 0 next cycle, 1 random delay, 2 never
   int inject_req = 0;
   int acc_reads = 0, acc_writes = 0, exp_reads = 0, exp_writes = 0;
   int last_cmd_len = 0, both_cmd = 0;
   bit err_model = 1'b0;

   initial begin : responder
      int stall = 0, held = 0, len = 0, rv_pend = -1, inject_ack = 0;
      logic [MEM_AW-3:0] h_addr;
      logic [31:0] h_wdata, rv_data;
      wr_t w;
      h_addr = '0; h_wdata = '0; rv_data = '0;
      forever begin
         @(negedge CLK);
         mem_rvalid = 1'b0;
         if (!RST_X) rv_pend = -1;
         if (inject_req != inject_ack) begin
            inject_ack = inject_req;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h12345678;
         end else if (rv_pend == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rv_data;
            rv_pend    = -1;
         end else if (rv_pend > 0) begin
            rv_pend--;
         end
         if (mem_we && mem_re) both_cmd++;
         if (!(mem_we || mem_re)) begin
            held = 0;
            mem_ready = 1'b0;
         end else begin
            if (held == 0) begin
               held = 1; len = 0; h_addr = mem_addr; h_wdata = mem_wdata;
               case (ready_mode)
                  0: stall = 0;
                  1: stall = $urandom_range(0, 4);
                  3: stall = 5;
                  default: stall = 1 << 30;
               endcase
            end else begin
               check("cmd_addr_stable", 32'(mem_addr), 32'(h_addr));
               if (mem_we) check("cmd_wdata_stable", mem_wdata, h_wdata);
            end
            len++;
            mem_ready = (stall == 0);
            if (stall > 0) stall--;
            if (mem_ready) begin
               last_cmd_len = len;
               held = 0;
               if (mem_re) begin
                  acc_reads++;
                  rdq.push_back(mem_addr);
                  rv_data = mem_rd(mem_addr);
                  rv_pend = (rv_mode == 0) ? 0 : (rv_mode == 1) ? $urandom_range(0, 3) : -1;
               end else begin
                  acc_writes++;
                  w.idx = mem_addr;
                  w.data = mem_wdata;
                  wrq.push_back(w);
                  mem[mem_addr] = mem_wdata;
               end
            end
         end
      end
   end

   initial begin : monitor
      int cyc = 0;
      exp_t e;
      wr_t w;
      forever begin
         @(posedge CLK);
         #1;
         if (sbq.size() != 0) begin
            if (w_dram_busy) cyc++;
            else begin
               e = sbq.pop_front();
               if (e.lat >= 0) check("busy_latency", cyc, e.lat);
               if (e.rd) begin
                  if (rdq.size() == 0) fail_now("read_issued");
                  else check("read_addr", rdq.pop_front(), e.idx);
               end
               if (e.wr) begin
                  if (wrq.size() == 0) fail_now("write_issued");
                  else begin
                     w = wrq.pop_front();
                     check("write_addr", w.idx, e.idx);
                     check("write_data", w.data, e.val);
                  end
               end
               if (e.is_load) check("load_data", w_dram_odata, e.val);
               check("r_err", 32'(r_err), 32'(e.err));
               cyc = 0;
            end
         end
      end
   end

   task automatic issue(input bit we, input bit le, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] wd, input bit fixed, input logic [31:0] fexp,
                        input int lat, input bit spur);
      exp_t e;
      int unsigned off, idx;
      logic [31:0] w;
      bit mis;
      @(negedge CLK);
      idx = (a & 32'h07FF_FFFF) >> 2;
      off = a % 4;
      mis = (c == LS_H || c == LS_HU) ? (off % 2 != 0) : (c == LS_W) ? (off != 0) : 1'b0;
      if (c == LS_H || c == LS_HU) off = off - off % 2;
      else if (c == LS_W) off = 0;
      w = mem_rd(idx);
      err_model = err_model | mis;
      e.idx = idx; e.err = err_model; e.lat = lat;
      if (we) begin
         e.is_load = 1'b0; e.wr = 1'b1; e.rd = (c != LS_W);
         e.val = (c == LS_W) ? wd : ref_merge(w, wd, off, c);
         exp_writes++;
         if (e.rd) exp_reads++;
      end else begin
         e.is_load = 1'b1; e.rd = 1'b1; e.wr = 1'b0;
         e.val = ref_load(w, off, c);
         exp_reads++;
      end
      if (fixed) e.val = fexp;
      sbq.push_back(e);
      w_dram_addr = a; w_dram_wdata = wd; w_dram_ctrl = c;
      w_dram_we_t = we; w_dram_le = le;
      #1 check("busy_in_strobe_cycle", 32'(w_dram_busy), 32'd1);
      for (int n = 0; n < 200 && sbq.size() != 0; n++) begin
         @(negedge CLK);
         w_dram_we_t = 1'b0; w_dram_le = 1'b0;
         #1;
         if (spur && w_dram_busy && $urandom_range(0, 3) == 0) begin
            w_dram_we_t  = 1'($urandom_range(0, 1));
            w_dram_le    = 1'($urandom_range(0, 1));
            w_dram_addr  = $urandom;
            w_dram_wdata = $urandom;
         end
      end
      @(negedge CLK);
      w_dram_we_t = 1'b0; w_dram_le = 1'b0;
      if (sbq.size() != 0) begin
         fail_now("request_completion");
         sbq.delete(); rdq.delete(); wrq.delete();
      end
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [2:0] ctrls [5];
      int n, op;
      logic [2:0] c;
      ctrls = '{LS_B, LS_H, LS_W, LS_BU, LS_HU};
      repeat (3) @(negedge CLK);
      check("rst_busy", 32'(w_dram_busy), 32'd0);
      check("rst_odata", w_dram_odata, 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_re", 32'(mem_re), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_r_err", 32'(r_err), 32'd0);
      RST_X = 1'b1;

      mem[32'h40] = 32'hDEADBEEF;
      issue(0, 1, LS_W, 32'h100, 0, 1, 32'hDEADBEEF, 2, 0);
      mem[32'h40] = 32'h80FF7F01;
      issue(0, 1, LS_B,  32'h103, 0, 1, 32'hFFFFFF80, 2, 0);
      issue(0, 1, LS_BU, 32'h103, 0, 1, 32'h00000080, 2, 0);
      issue(0, 1, LS_H,  32'h102, 0, 1, 32'hFFFF80FF, 2, 0);
      issue(0, 1, LS_HU, 32'h102, 0, 1, 32'h000080FF, 2, 0);
      mem[32'h80] = 32'h11223344;
      issue(1, 0, LS_B, 32'h201, 32'h000000AA, 1, 32'h1122AA44, 3, 0);
      mem[32'h80] = 32'h11223344;
      issue(1, 0, LS_H, 32'h202, 32'h0000BEEF, 1, 32'hBEEF3344, 3, 0);

      ready_mode = 3;
      issue(1, 0, LS_W, 32'h300, 32'hCAFEF00D, 1, 32'hCAFEF00D, 6, 0);
      ready_mode = 0;
      check("stall_cmd_len", last_cmd_len, 6);

      issue(1, 1, LS_W, 32'h304, 32'h01020304, 1, 32'h01020304, 1, 0);
      check("no_err_before_misalign", 32'(r_err), 32'd0);
      mem[32'h40] = 32'h80FF7F01;
      issue(0, 1, LS_H, 32'h101, 0, 1, 32'h00007F01, 2, 0);

      ready_mode = 1; rv_mode = 1;
      for (int i = 0; i < 150; i++) begin
         op = $urandom_range(0, 2);
         c  = ctrls[$urandom_range(0, 4)];
         issue(op != 0, op != 1, c,
               ($urandom & 32'hF800_0000) | 32'h400 | $urandom_range(0, 63),
               $urandom, 0, 0, -1, 1);
      end
      ready_mode = 0; rv_mode = 0;
      mem[32'h50] = 32'h13572468;
      issue(0, 1, LS_W, 32'h140, 0, 1, 32'h13572468, 2, 0);

      rv_mode = 2;
      @(negedge CLK);
      w_dram_addr = 32'h140; w_dram_ctrl = LS_W; w_dram_le = 1'b1;
      @(negedge CLK);
      w_dram_le = 1'b0;
      @(negedge CLK);
      check("rd_wait_busy", 32'(w_dram_busy), 32'd1);
      check("rd_wait_no_re", 32'(mem_re), 32'd0);
      exp_reads++;
      RST_X = 1'b0;
      @(negedge CLK);
      RST_X = 1'b1;
      err_model = 1'b0;
      check("midrst_busy", 32'(w_dram_busy), 32'd0);
      check("midrst_odata", w_dram_odata, 32'd0);
      check("midrst_r_err", 32'(r_err), 32'd0);
      inject_req++;
      repeat (3) @(negedge CLK);
      check("late_rvalid_odata", w_dram_odata, 32'd0);
      check("late_rvalid_busy", 32'(w_dram_busy), 32'd0);
      check("late_rvalid_cmd", 32'(mem_re | mem_we), 32'd0);
      rdq.delete();

      ready_mode = 2; rv_mode = 0;
      @(negedge CLK);
      w_dram_addr = 32'h180; w_dram_ctrl = LS_W; w_dram_wdata = 32'h1; w_dram_we_t = 1'b1;
      @(negedge CLK);
      w_dram_we_t = 1'b0;
      n = 0;
      for (int k = 0; k < 40 && mem_we; k++) begin
         n++;
         @(negedge CLK);
      end
      check("wr_timeout_cycles", n, TMO);
      check("wr_timeout_busy", 32'(w_dram_busy), 32'd0);
      check("wr_timeout_err", 32'(r_err), 32'd1);

      ready_mode = 0; rv_mode = 2;
      @(negedge CLK);
      w_dram_addr = 32'h1C0; w_dram_ctrl = LS_W; w_dram_le = 1'b1;
      @(negedge CLK);
      w_dram_le = 1'b0;
      n = 0;
      for (int k = 0; k < 40 && w_dram_busy; k++) begin
         n++;
         @(negedge CLK);
      end
      exp_reads++;
      rdq.delete();
      rv_mode = 0;
      check("rd_timeout_cycles", n, 1 + TMO);
      check("rd_timeout_odata", w_dram_odata, 32'hFFFFFFFF);
      check("rd_timeout_err", 32'(r_err), 32'd1);

      repeat (2) @(negedge CLK);
      check("total_reads", acc_reads, exp_reads);
      check("total_writes", acc_writes, exp_writes);
      check("we_re_overlap", both_cmd, 0);
      check("leftover_writes", wrq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
